// File: rtl/display_pkg.sv
// Shared screen codes, sequencer states and helpers for the pet-feeder VGA display path.
package display_pkg;

    localparam logic [1:0] SCR_DIM     = 2'd0;
    localparam logic [1:0] SCR_WELCOME = 2'd1;
    localparam logic [1:0] SCR_IDLE    = 2'd2;
    localparam logic [1:0] SCR_ALERT   = 2'd3;

    // Sequencer states share encodings with the screen codes so screen_sel is the state register.
    typedef logic [1:0] disp_state_t;
    localparam disp_state_t StDim     = SCR_DIM;
    localparam disp_state_t StWelcome = SCR_WELCOME;
    localparam disp_state_t StIdle    = SCR_IDLE;
    localparam disp_state_t StAlert   = SCR_ALERT;

    localparam int unsigned SET_MODE_BIT = 4;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/display_sequencer_blink_gen.sv
// Frame-based blink generator for the set-time digit highlight.
module blink_gen #(
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_start,
    input  logic enable,
    output logic blink_on,
    output logic blink_on_next
);

    localparam int unsigned CntW = $clog2(BLINK_FRAMES) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(BLINK_FRAMES - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    logic [CntW-1:0] blink_cnt_q, blink_cnt_d;
    logic            blink_on_q, blink_on_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (!enable) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (frame_start) begin
            if (blink_cnt_q == LastCnt) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else if (blink_cnt_q != '1) begin
                blink_cnt_d = blink_cnt_q + CntOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    assign blink_on      = blink_on_q;
    assign blink_on_next = blink_on_d;

endmodule

// File: rtl/display_sequencer.sv
// Screen-level sequencer: picks the rendered screen and gates the set-time highlight blink.
// Optional macro DISPLAY_DIM_EN enables the idle-timeout DIM screen and the dim output.
module display_sequencer
    import display_pkg::*;
#(
    parameter int unsigned WELCOME_FRAMES      = 180,
    parameter int unsigned ALERT_FRAMES        = 300,
    parameter int unsigned IDLE_TIMEOUT_FRAMES = 1800,
    parameter int unsigned BLINK_FRAMES        = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic [5:0] state,
    input  logic       feed_evt,
    input  logic       btn_any,
    output logic [1:0] screen_sel,
    output logic       highlight_en,
    output logic       dim,
    output logic       welcome_done
);

`ifdef DISPLAY_DIM_EN
    localparam int unsigned MaxFrames =
        max_u(max_u(WELCOME_FRAMES, ALERT_FRAMES), IDLE_TIMEOUT_FRAMES);
`else
    localparam int unsigned MaxFrames = max_u(WELCOME_FRAMES, ALERT_FRAMES);
    localparam int unsigned unused_idle_frames = IDLE_TIMEOUT_FRAMES;
`endif
    localparam int unsigned CntW = $clog2(MaxFrames) + 1;
    localparam logic [CntW-1:0] WelcomeLast = CntW'(WELCOME_FRAMES - 1);
    localparam logic [CntW-1:0] AlertLast   = CntW'(ALERT_FRAMES - 1);
`ifdef DISPLAY_DIM_EN
    localparam logic [CntW-1:0] IdleLast    = CntW'(IDLE_TIMEOUT_FRAMES - 1);
`endif
    localparam logic [CntW-1:0] CntOne      = CntW'(1);

    disp_state_t     state_q, state_d;
    logic [CntW-1:0] frame_cnt_q, frame_cnt_d, frame_cnt_inc;
    logic            pend_feed_q, pend_feed_d, pend_btn_q, pend_btn_d;
    logic            welcome_done_q, welcome_done_d;
    logic            highlight_q, highlight_d;
    logic            feed_now, btn_now, set_mode;
    logic            blink_on, blink_on_next;
    logic            unused_state;

    assign set_mode      = state[SET_MODE_BIT];
    assign unused_state  = ^{state[5], state[3:0]};
    assign feed_now      = pend_feed_q | feed_evt;
    assign btn_now       = pend_btn_q | btn_any;
    assign frame_cnt_inc = (frame_cnt_q == '1) ? frame_cnt_q : frame_cnt_q + CntOne;

    always_comb begin
        state_d        = state_q;
        frame_cnt_d    = frame_cnt_q;
        pend_feed_d    = pend_feed_q | feed_evt;
        pend_btn_d     = pend_btn_q | btn_any;
        welcome_done_d = welcome_done_q;
        if (frame_start) begin
            pend_feed_d = 1'b0;
            pend_btn_d  = 1'b0;
            frame_cnt_d = frame_cnt_inc;
            unique case (state_q)
                StWelcome: begin
                    if (feed_now) begin
                        state_d = StAlert;
                    end else if (btn_now || frame_cnt_q == WelcomeLast) begin
                        state_d = StIdle;
                    end
                end
                StIdle: begin
                    if (feed_now) begin
                        state_d = StAlert;
                    end else if (btn_now || set_mode) begin
                        frame_cnt_d = '0;
`ifdef DISPLAY_DIM_EN
                    end else if (frame_cnt_q == IdleLast) begin
                        state_d = StDim;
`endif
                    end
                end
                StAlert: begin
                    if (feed_now) begin
                        frame_cnt_d = '0;
                    end else if (btn_now || frame_cnt_q == AlertLast) begin
                        state_d = StIdle;
                    end
                end
                StDim: begin
                    if (feed_now) begin
                        state_d = StAlert;
                    end else if (btn_now || set_mode) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StWelcome;
            endcase
            if (state_d != state_q) begin
                frame_cnt_d = '0;
            end
            if (state_q == StWelcome && state_d != StWelcome) begin
                welcome_done_d = 1'b1;
            end
        end
    end

    // Uses next-state values so the highlight lines up with screen_sel and the blink phase.
    assign highlight_d = set_mode & blink_on_next & (state_d == StIdle);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= StWelcome;
            frame_cnt_q    <= '0;
            pend_feed_q    <= 1'b0;
            pend_btn_q     <= 1'b0;
            welcome_done_q <= 1'b0;
            highlight_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            frame_cnt_q    <= frame_cnt_d;
            pend_feed_q    <= pend_feed_d;
            pend_btn_q     <= pend_btn_d;
            welcome_done_q <= welcome_done_d;
            highlight_q    <= highlight_d;
        end
    end

`ifdef DISPLAY_DIM_EN
    logic dim_q;
    always_ff @(posedge clk) begin
        if (!reset) begin
            dim_q <= 1'b0;
        end else begin
            dim_q <= (state_d == StDim);
        end
    end
    assign dim = dim_q;
`else
    assign dim = 1'b0;
`endif

    blink_gen #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink_gen (
        .clk          (clk),
        .reset        (reset),
        .frame_start  (frame_start),
        .enable       (set_mode),
        .blink_on     (blink_on),
        .blink_on_next(blink_on_next)
    );

    assign screen_sel   = state_q;
    assign highlight_en = highlight_q;
    assign welcome_done = welcome_done_q;

endmodule

// File: tb/tb_display_sequencer.sv
// Scoreboard bench for display_sequencer with short frame parameters.
module tb_display_sequencer;

    localparam int unsigned WF = 4;
    localparam int unsigned AF = 3;
    localparam int unsigned IF = 5;
    localparam int unsigned BF = 2;
`ifdef DISPLAY_DIM_EN
    localparam bit DimEn = 1'b1;
`else
    localparam bit DimEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_start = 1'b0;
    logic       feed_evt = 1'b0;
    logic       btn_any = 1'b0;
    logic [5:0] state = 6'd0;
    logic [1:0] screen_sel;
    logic       highlight_en;
    logic       dim;
    logic       welcome_done;

    display_sequencer #(
        .WELCOME_FRAMES     (WF),
        .ALERT_FRAMES       (AF),
        .IDLE_TIMEOUT_FRAMES(IF),
        .BLINK_FRAMES       (BF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .state       (state),
        .feed_evt    (feed_evt),
        .btn_any     (btn_any),
        .screen_sel  (screen_sel),
        .highlight_en(highlight_en),
        .dim         (dim),
        .welcome_done(welcome_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] v;
        string      name;
    } exp_t;

    exp_t sb[$];
    logic sample = 1'b0;
    logic done = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the expected {screen_sel, dim, highlight_en, welcome_done}; monitor checks it.
    task automatic chk(input logic [1:0] scr, input logic hl, input logic wd, input string name);
        exp_t e;
        e.v    = {scr, (scr == 2'd0), hl, wd};
        e.name = name;
        sb.push_back(e);
        sample = 1'b1;
        tick();
        sample = 1'b0;
    endtask

    task automatic frame(input logic f, input logic b);
        frame_start = 1'b1;
        feed_evt    = f;
        btn_any     = b;
        tick();
        frame_start = 1'b0;
        feed_evt    = 1'b0;
        btn_any     = 1'b0;
    endtask

    task automatic pulse(input logic f, input logic b);
        feed_evt = f;
        btn_any  = b;
        tick();
        feed_evt = 1'b0;
        btn_any  = 1'b0;
    endtask

    task automatic set_mode(input logic on);
        state = on ? 6'b010011 : 6'b000101;
        tick();
    endtask

    always @(negedge clk) begin
        exp_t       e;
        logic [4:0] got;
        got = {screen_sel, dim, highlight_en, welcome_done};
        if (sample) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_underflow: sample with no expectation queued");
            end else begin
                e = sb.pop_front();
                if (got !== e.v) begin
                    n_fail++;
                    $display("FAIL %s: got scr=%0d dim=%b hl=%b wd=%b, required scr=%0d dim=%b hl=%b wd=%b",
                             e.name, got[4:3], got[2], got[1], got[0],
                             e.v[4:3], e.v[2], e.v[1], e.v[0]);
                end
            end
        end
        if (done) begin
            n_checks++;
            if (sb.size() != 0) begin
                n_fail++;
                $display("FAIL scoreboard_drain: %0d left, required 0", sb.size());
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        reset = 1'b1;
        chk(2'd1, 1'b0, 1'b0, "reset");

        // Welcome lasts four frames.
        for (int i = 1; i <= 4; i++) begin
            frame(1'b0, 1'b0);
            chk((i == 4) ? 2'd2 : 2'd1, 1'b0, (i == 4), "welcome");
        end

        // Mid-frame feed waits for the next frame, then alert lasts three frames.
        pulse(1'b1, 1'b0);
        chk(2'd2, 1'b0, 1'b1, "feed_wait");
        frame(1'b0, 1'b0);
        chk(2'd3, 1'b0, 1'b1, "alert_enter");
        for (int i = 1; i <= 3; i++) begin
            frame(1'b0, 1'b0);
            chk((i == 3) ? 2'd2 : 2'd3, 1'b0, 1'b1, "alert_expire");
        end

        // Same-cycle feed counts; feed beats btn and restarts the alert count.
        frame(1'b1, 1'b0);
        chk(2'd3, 1'b0, 1'b1, "alert_live");
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        chk(2'd3, 1'b0, 1'b1, "both_pending");
        frame(1'b0, 1'b0);
        chk(2'd3, 1'b0, 1'b1, "prio_restart");
        frame(1'b0, 1'b0);
        chk(2'd3, 1'b0, 1'b1, "alert_f1");
        frame(1'b1, 1'b0);
        chk(2'd3, 1'b0, 1'b1, "refeed");
        for (int i = 1; i <= 3; i++) begin
            frame(1'b0, 1'b0);
            chk((i == 3) ? 2'd2 : 2'd3, 1'b0, 1'b1, "refeed_expire");
        end

        // Idle timeout to DIM (only when the feature is built in), then wake on a button.
        for (int i = 1; i <= 5; i++) begin
            frame(1'b0, 1'b0);
            chk((DimEn && i == 5) ? 2'd0 : 2'd2, 1'b0, 1'b1, "idle_timeout");
        end
        pulse(1'b0, 1'b1);
        chk(DimEn ? 2'd0 : 2'd2, 1'b0, 1'b1, "dim_hold");
        frame(1'b0, 1'b0);
        chk(2'd2, 1'b0, 1'b1, "wake_btn");
        for (int i = 1; i <= 7; i++) begin
            frame(1'b0, 1'b0);
            chk((DimEn && i >= 5) ? 2'd0 : 2'd2, 1'b0, 1'b1, "dim_again");
        end

        // Set-time mode wakes from DIM and blinks the highlight 1,1,0,0,1,1.
        set_mode(1'b1);
        chk(DimEn ? 2'd0 : 2'd2, !DimEn, 1'b1, "set_on");
        frame(1'b0, 1'b0);
        chk(2'd2, 1'b1, 1'b1, "blink_f1");
        for (int i = 0; i < 4; i++) begin
            frame(1'b0, 1'b0);
            chk(2'd2, (i >= 2), 1'b1, "blink_pattern");
        end
        frame(1'b0, 1'b0);
        chk(2'd2, 1'b0, 1'b1, "blink_f6");
        set_mode(1'b0);
        chk(2'd2, 1'b0, 1'b1, "set_off");
        set_mode(1'b1);
        chk(2'd2, 1'b1, 1'b1, "blink_reset");
        set_mode(1'b0);
        chk(2'd2, 1'b0, 1'b1, "hl_drop");

        // Reset during ALERT with a pending button discards everything.
        frame(1'b1, 1'b0);
        chk(2'd3, 1'b0, 1'b1, "alert_again");
        pulse(1'b0, 1'b1);
        chk(2'd3, 1'b0, 1'b1, "pend_btn");
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk(2'd1, 1'b0, 1'b0, "mid_reset");
        for (int i = 1; i <= 4; i++) begin
            frame(1'b0, 1'b0);
            chk((i == 4) ? 2'd2 : 2'd1, 1'b0, (i == 4), "post_reset");
        end

        tick();
        done = 1'b1;
    end

endmodule

// File: doc/display_sequencer.md
# display_sequencer

Screen-level controller for the pet-feeder VGA path. Decides which screen the renderers draw (welcome banner, idle clock, feed alert, dimmed) and gates the set-time digit highlight with a blink. Timing is counted in frames. All screen changes are committed only at frame boundaries, so the picture never tears mid-frame. Sits between the main feeder FSM and the tile/sprite renderers; its outputs select and gate their pixel outputs.

## Interface
- WELCOME_FRAMES, 180: frames the banner is shown after reset.
- ALERT_FRAMES, 300: frames the feed alert is shown.
- IDLE_TIMEOUT_FRAMES, 1800: inactive frames before dimming.
- BLINK_FRAMES, 30: frames per highlight blink half-period.
- clk  in  1  pixel/system clock; single clock domain.
- reset  in  1  synchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- state  in  6  main FSM state; state[4]=1 means set-time mode.
- feed_evt  in  1  one-cycle pulse when food is dispensed.
- btn_any  in  1  one-cycle pulse on any user button press.
- screen_sel  out  2  screen code: 0 DIM, 1 WELCOME, 2 IDLE, 3 ALERT.
- highlight_en  out  1  digit-highlight enable for the clock renderer.
- dim  out  1  high while screen_sel is DIM.
- welcome_done  out  1  sticky; set on the first exit from WELCOME.

## Operation
- **Event latching.** feed_evt and btn_any set sticky pend_feed / pend_btn bits.
  - At frame_start, the decision uses (pend | live pulse).
  - Both pend bits clear on that cycle.
- **Frame counter.** frame_cnt increments on each frame_start. It resets to 0 on every state transition.
- **WELCOME**
  - btn_any → IDLE.
  - frame_cnt reaching WELCOME_FRAMES-1 → IDLE.
  - feed_evt → ALERT; feed has priority over btn.
- **IDLE**
  - feed_evt → ALERT.
  - btn_any, or state[4]=1 at frame_start, restarts frame_cnt.
  - frame_cnt reaching IDLE_TIMEOUT_FRAMES-1 → DIM.
- **ALERT**
  - feed_evt restarts frame_cnt; this wins over btn.
  - btn_any → IDLE.
  - frame_cnt reaching ALERT_FRAMES-1 → IDLE.
- **DIM**
  - feed_evt → ALERT.
  - btn_any → IDLE.
  - state[4]=1 → IDLE.
- **Blink.** blink_cnt counts frames while state[4]=1.
  - blink_on toggles when blink_cnt reaches BLINK_FRAMES-1; blink_cnt then wraps to 0.
  - When state[4]=0: blink_cnt=0 and blink_on=1.
- **Highlight.** highlight_en = state[4] & blink_on & (screen_sel==IDLE).
- **Counter width.** Counters are $clog2(max parameter)+1 bits and saturate at all-ones. They never wrap back into the timeout window.

## Timing
- Reset values:
  - screen_sel=1 (WELCOME); FSM state WELCOME.
  - highlight_en=0, dim=0, welcome_done=0.
  - frame_cnt=0, blink_cnt=0, blink_on=1.
  - pend_feed=0, pend_btn=0.
- All outputs are registered. screen_sel and dim change exactly one cycle after the deciding frame_start, never at any other time.
- An event arriving on the same cycle as frame_start counts for that frame.
- An event arriving one cycle after frame_start waits for the next frame_start.
- highlight_en follows a state[4] change with 1-cycle latency; its blink phase changes only at frame_start.
- Multiple events between frames collapse into one.
- Reset asserted mid-operation returns everything to the reset values on the next edge. Pending events are discarded.

## Configuration
- Macro: DISPLAY_DIM_EN.
- Defined: DIM state, idle timeout and the dim output exist as described.
- Undefined:
  - IDLE never times out and DIM is unreachable.
  - dim is tied to 0; screen code 0 is never produced.
  - The IDLE_TIMEOUT_FRAMES parameter is ignored.

## Structure
- Shared package display_pkg holds:
  - screen codes SCR_DIM/SCR_WELCOME/SCR_IDLE/SCR_ALERT (2-bit);
  - the FSM state enum;
  - SET_MODE_BIT=4.
- The renderers import the same screen codes.
- One sub-module, blink_gen: blink_cnt/blink_on with inputs clk, reset, frame_start, enable.

## Test plan
Parameters for the bench: WELCOME_FRAMES=4, ALERT_FRAMES=3, IDLE_TIMEOUT_FRAMES=5, BLINK_FRAMES=2.
- **Reset and welcome.** Release reset, pulse 4 frame_start → screen_sel=1 through the 3rd frame, =2 one cycle after the 4th; welcome_done=1.
- **Alert timing.** feed_evt mid-frame in IDLE → screen_sel=3 one cycle after the next frame_start, back to 2 after 3 further frames.
- **Alert restart and priority.** feed_evt and btn_any in the same frame during ALERT → stays 3 and alert count restarts; a second feed_evt at frame 2 extends the alert to 3 frames from that point.
- **Dim and wake.** Idle 5 frames → screen_sel=0, dim=1; btn_any → 2 at the next frame_start. Repeat with DISPLAY_DIM_EN undefined → stays 2 forever.
- **Blink.** state[4]=1 in IDLE → highlight_en pattern 1,1,0,0,1,1 per frame; state[4]=0 → highlight_en=0 next cycle and blink_on=1.
- **Reset mid-alert.** Assert reset low for one cycle during ALERT with pend_btn set → screen_sel=1, all counters 0, no IDLE transition at the following frame_start.
